// File: rtl/mem_stage_lsu.sv
// MEM stage load/store unit: byte-enabled data memory, sub-word extract/extend,
// misalignment trap, configurable access latency with stall, and MEM/WB register.
module mem_stage_lsu #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int MEM_LATENCY = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_m,
    input  logic            flush_m,
    input  logic            reg_write_m,
    input  logic [1:0]      result_src_m,
    input  logic            mem_read_m,
    input  logic            mem_write_m,
    input  logic [2:0]      funct3_m,
    input  logic [XLEN-1:0] alu_result_m,
    input  logic [XLEN-1:0] write_data_m,
    input  logic [4:0]      rd_m,
    input  logic [XLEN-1:0] pc_plus4_m,
    output logic            stall_m,
    output logic            valid_w,
    output logic            reg_write_w,
    output logic [1:0]      result_src_w,
    output logic [XLEN-1:0] alu_result_w,
    output logic [XLEN-1:0] read_data_w,
    output logic [4:0]      rd_w,
    output logic [XLEN-1:0] pc_plus4_w,
    output logic            misalign_w
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam bit         HAS_WAIT = (MEM_LATENCY > 0);
    localparam logic [2:0] LAT_M1   = HAS_WAIT ? 3'(MEM_LATENCY - 1) : 3'd0;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [AW-1:0] w_idx;
    logic [1:0]    w_off;
    logic          w_is_b, w_is_h, w_is_w, w_is_mem, w_misalign, w_req;
    logic          w_stall, w_done, w_we;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_word, w_shift, w_load, w_rdata;
    logic [15:0]   w_half;

    assign w_idx      = alu_result_m[AW+1:2];
    assign w_off      = alu_result_m[1:0];
    // Undefined sizes (x11) fall into the word class.
    assign w_is_b     = (funct3_m[1:0] == 2'b00);
    assign w_is_h     = (funct3_m[1:0] == 2'b01);
    assign w_is_w     = !(w_is_b || w_is_h);
    assign w_is_mem   = mem_read_m || mem_write_m;
    assign w_misalign = w_is_mem && ((w_is_h && w_off[0]) || (w_is_w && (w_off != 2'b00)));
    assign w_req      = valid_m && !flush_m && w_is_mem && !w_misalign;

    always_comb begin
        w_stall = 1'b0;
        if (!reset && !flush_m) begin
            case (r_state)
                IDLE:    w_stall = w_req && HAS_WAIT;
                WAIT:    w_stall = (r_cnt != 3'd0);
                default: w_stall = 1'b0;
            endcase
        end
    end

    assign stall_m = w_stall;
    assign w_done  = !w_stall && !flush_m;
    assign w_we    = w_done && valid_m && mem_write_m && !w_misalign && !reset;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = write_data_m[31:0];
        if (w_is_b) begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{write_data_m[7:0]}};
        end else if (w_is_h) begin
            w_be    = w_off[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{write_data_m[15:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {w_off, 3'b000};
    assign w_half  = w_off[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        case (funct3_m)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = w_word;
        endcase
    end

    // A combined read+write performs only the store, so its load data is zero.
    assign w_rdata = (valid_m && mem_read_m && !mem_write_m && !w_misalign) ? w_load : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else if (flush_m) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            case (r_state)
                IDLE: if (w_req && HAS_WAIT) begin
                    r_state <= WAIT;
                    r_cnt   <= LAT_M1;
                end
                WAIT: if (r_cnt == 3'd0) r_state <= IDLE;
                      else               r_cnt   <= r_cnt - 3'd1;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_w      <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= 2'b00;
            alu_result_w <= '0;
            read_data_w  <= '0;
            rd_w         <= 5'd0;
            pc_plus4_w   <= '0;
            misalign_w   <= 1'b0;
        end else if (w_stall || flush_m) begin
            valid_w      <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= 2'b00;
            alu_result_w <= '0;
            read_data_w  <= '0;
            rd_w         <= 5'd0;
            pc_plus4_w   <= '0;
            misalign_w   <= 1'b0;
        end else begin
            valid_w      <= valid_m;
            reg_write_w  <= valid_m && reg_write_m && !w_misalign;
            result_src_w <= result_src_m;
            alu_result_w <= alu_result_m;
            read_data_w  <= XLEN'(w_rdata);
            rd_w         <= rd_m;
            pc_plus4_w   <= pc_plus4_m;
            misalign_w   <= valid_m && w_misalign;
        end
    end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised successor to the single-cycle MEM stage of the 5-stage RISC-V pipeline.
- Adds sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte enables, misalignment detection, configurable data-memory latency with a stall handshake, and flush.
- Contains the data-memory array and the MEM/WB pipeline register.
- Sits between the execute-stage EX/MEM register and writeback.

Parameters:
- XLEN, 32: datapath width; only 32 is supported.
- DEPTH_WORDS, 1024: data memory depth in 32-bit words; must be a power of two. AW = log2(DEPTH_WORDS).
- MEM_LATENCY, 0: extra wait cycles per load/store, range 0..7. A value of 0 gives single-cycle access.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- valid_m  in  1  instruction present in M
- flush_m  in  1  kill instruction in M
- reg_write_m  in  1  register writeback enable
- result_src_m  in  2  writeback select (00 ALU, 01 load, 10 PC+4)
- mem_read_m  in  1  load
- mem_write_m  in  1  store
- funct3_m  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- alu_result_m  in  XLEN  effective address / ALU result
- write_data_m  in  XLEN  store data
- rd_m  in  5  destination register
- pc_plus4_m  in  XLEN  PC+4
- stall_m  out  1  M stage busy; upstream holds all inputs
- valid_w  out  1  WB valid
- reg_write_w  out  1  registered write enable
- result_src_w  out  2  registered writeback select
- alu_result_w  out  XLEN  registered ALU result
- read_data_w  out  XLEN  registered, extended load data
- rd_w  out  5  registered destination register
- pc_plus4_w  out  XLEN  registered PC+4
- misalign_w  out  1  registered misaligned-access flag

Behaviour:
- Reset: asynchronous, active-high.
  - All outputs and WB registers go to 0; FSM returns to IDLE; wait counter cleared.
  - Memory array is not reset.
  - Reset asserted mid-access aborts the access with no write.
- Addressing: word index = alu_result_m[AW+1:2]; upper address bits are ignored (wrap-around).
- Misalignment:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - A misaligned access performs no write, sets read data to 0, forces reg_write_w=0, and sets misalign_w=1 with valid_w=1.
  - It completes in one cycle with no wait states.
- Stores:
  - SB writes byte lane addr[1:0] with write_data[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with write_data[15:0].
  - SW writes all four lanes.
  - The write occurs on the completion edge only.
- Loads:
  - Data is extracted from the selected lane(s).
  - B/H are sign-extended; BU/HU are zero-extended; W is passed through.
  - Undefined funct3 values are treated as W.
- FSM states: IDLE, WAIT.
  - IDLE: if valid_m, no flush, access is a load/store, aligned, and MEM_LATENCY>0 → WAIT; counter loads MEM_LATENCY-1; stall_m=1 (combinational from IDLE for that request).
  - WAIT: stall_m=1 and the counter decrements. When the counter reaches 0, stall_m drops; the access completes at the next edge and the FSM returns to IDLE.
  - With MEM_LATENCY=0 the FSM stays in IDLE; every access completes in one cycle with one-cycle latency to WB.
- WB register:
  - Each edge while stall_m=1, the WB register loads a bubble (valid_w=0, reg_write_w=0, misalign_w=0).
  - On the completion edge it captures all M fields and load data.
  - Non-memory instructions and !valid_m pass through in one cycle (valid_w=valid_m).
- Flush:
  - flush_m=1 aborts any pending access: no write, FSM returns to IDLE, counter cleared, stall_m=0, bubble loaded into WB.
  - Flush coinciding with the completion edge: flush wins and no write occurs.
- A store and a load never hold the bus simultaneously. If mem_read_m and mem_write_m are both 1, the store is performed and the load data is 0.

Test Plan:
- MEM_LATENCY=0: SW 0xDEADBEEF to 0x10, then LW 0x10 → read_data_w=0xDEADBEEF one cycle after each request; stall_m never asserted.
- SB 0x80 to 0x13, then LB 0x13 → read_data_w=0xFFFFFF80; LBU 0x13 → 0x00000080; LH 0x12 → 0xFFFF80AD (with prior word 0xDEADBEEF → 0x80ADBEEF).
- LH 0x11 → misalign_w=1, reg_write_w=0, read_data_w=0, memory unchanged; SW 0x22 → no write; verify by a later LW 0x20.
- MEM_LATENCY=3: LW issued → stall_m high for exactly 3 cycles, 3 bubbles in WB, then valid_w=1 with correct data; inputs held stable throughout.
- MEM_LATENCY=3: SW issued, flush_m pulsed in the 2nd stall cycle → stall_m drops the same cycle, bubble in WB, memory unchanged; reset pulsed mid-WAIT → all outputs 0, FSM in IDLE.
- Address wrap: DEPTH_WORDS=1024, SW to 0x1000 then LW 0x0000 → same data.
